// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ requesters.
// Optional macro REGFILE_ARB_STATS_EN adds a saturating conflict_count output.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             hold,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
`ifdef REGFILE_ARB_STATS_EN
    output logic [15:0]                      conflict_count,
`endif
    output logic                             busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]    grant_oh;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_vld;

    // Search from rr_ptr upward with wrap; reset and hold suppress every grant.
    always_comb begin
        int idx;
        idx       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (!clr && !hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld     = 1'b1;
                    grant_idx     = PTR_W'(idx);
                    grant_oh[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Register 0 is hardwired: the request is consumed but never written.
            if (addr_arr[grant_idx] != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_arr[grant_idx];
                wr_data_d = data_arr[grant_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign req_ready = grant_oh;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (|req_valid) & (hold | clr);

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_count_q, conflict_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        if (!hold && ($countones(req_valid) > 1) && (conflict_count_q != 16'hFFFF))
            conflict_count_d = conflict_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (clr)
            conflict_count_q <= '0;
        else
            conflict_count_q <= conflict_count_d;
    end

    assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected regfile writes into a queue,
// a negedge monitor pops and compares whenever wr_en is presented.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              clr;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0]       conflict_count;
`endif

    logic [AW-1:0]     addr_a [N];
    logic [DW-1:0]     data_a [N];

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = addr_a[i];
            req_data[i*DW +: DW] = data_a[i];
        end
    end

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef REGFILE_ARB_STATS_EN
        .conflict_count (conflict_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q [$];

    function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, actual, $time);
        end
    endfunction

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(int r);
        wr_t e;
        e.addr = addr_a[r];
        e.data = data_a[r];
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1;
        hold = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'(i + 1);
            data_a[i] = 32'hA0 + 32'(i);
        end

        // Reset with all requesters valid
        #2;
        check("rst_ready0", 32'(req_ready), 32'h0);
        check("rst_busy0", 32'(busy), 32'h1);
        tick();
        check("rst_ready1", 32'(req_ready), 32'h0);
        tick();
        clr = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_first_grant", 32'(req_ready), 32'b0001);
        check("rst_busy_off", 32'(busy), 32'h0);
        req_valid = 4'b0000;
        tick();

        // Single requester 2
        addr_a[2] = 5'd7;
        data_a[2] = 32'hDEADBEEF;
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        expect_write(2);
        tick();
        req_valid = 4'b0000;
        check("single_wr_en", 32'(wr_en), 32'h1);
        tick();
        check("single_wr_en_off", 32'(wr_en), 32'h0);

        // Re-reset to bring the pointer back to 0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'(i + 1);
            data_a[i] = 32'hC0DE_0000 + 32'(i);
        end

        // Full contention: grant order 0,1,2,3,0,1,2,3
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("contend_ready_%0d", k), 32'(req_ready), 32'(1 << (k % N)));
            expect_write(k % N);
            tick();
        end
        req_valid = 4'b0000;
        tick();
        check("contend_wr_en_off", 32'(wr_en), 32'h0);
        check("contend_last_addr", 32'(wr_addr), 32'd4);
`ifdef REGFILE_ARB_STATS_EN
        check("conflict_count", 32'(conflict_count), 32'd8);
`endif

        // Register 0 write: consumed, not written, pointer to 2
        addr_a[1] = 5'd0;
        data_a[1] = 32'h12345678;
        req_valid = 4'b0010;
        #1;
        check("r0_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        check("r0_wr_en", 32'(wr_en), 32'h0);
        check("r0_wr_addr_hold", 32'(wr_addr), 32'd4);
        check("r0_wr_data_hold", wr_data, 32'hC0DE_0003);

        // Hold with pointer at 2: requester 3 first after release, then 0
        addr_a[3] = 5'd9;
        data_a[3] = 32'h3333_3333;
        addr_a[0] = 5'd10;
        data_a[0] = 32'h0000_AAAA;
        req_valid = 4'b1001;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold_ready_%0d", k), 32'(req_ready), 32'h0);
            check($sformatf("hold_busy_%0d", k), 32'(busy), 32'h1);
            tick();
            check($sformatf("hold_wr_en_%0d", k), 32'(wr_en), 32'h0);
        end
        hold = 1'b0;
        #1;
        check("hold_rel_ready3", 32'(req_ready), 32'b1000);
        expect_write(3);
        tick();
        req_valid = 4'b0001;
        #1;
        check("hold_rel_ready0", 32'(req_ready), 32'b0001);
        expect_write(0);
        tick();
        req_valid = 4'b0000;
        tick();

        // Mid-stream reset while requester 2 would otherwise be granted
        addr_a[2] = 5'd11;
        data_a[2] = 32'h2222_2222;
        req_valid = 4'b0100;
        clr = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_busy", 32'(busy), 32'h1);
        tick();
        clr = 1'b0;
        check("midrst_wr_en", 32'(wr_en), 32'h0);
        req_valid = 4'b0101;
        #1;
        check("midrst_resume0", 32'(req_ready), 32'b0001);
        expect_write(0);
        tick();
        req_valid = 4'b0100;
        #1;
        check("midrst_resume2", 32'(req_ready), 32'b0100);
        expect_write(2);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
